// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: memory handshake, datapath strobes and a retired-instruction counter.
// Optional build macro MCU_MEM_TIMEOUT_EN adds a memory-wait watchdog that pulses mem_err and refetches.
module multicycle_control_unit #(
    parameter int OPCODE_W       = 4,
    parameter int ALU_OP_W       = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] instr_opcode,
    input  logic                zero_flag,
    input  logic                mem_ack,
    input  logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_is_fetch,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                imm_load,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal_op,
    output logic                mem_err,
    output logic [CNT_W-1:0]    retired,
    output logic [2:0]          state
);

    // state  | meaning
    // FETCH  | instruction fetch request outstanding
    // DECODE | classify opcode, latch it into op_q
    // EXEC   | single ALU cycle
    // MEM    | data load/store request outstanding
    // WB     | register-file write
    // BRANCH | conditional PC load
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDR = 4'h8;
    localparam logic [3:0] OP_STR = 4'h9;
    localparam logic [3:0] OP_IMM = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hD;
    localparam logic [3:0] OP_BNE = 4'hE;
    localparam logic [3:0] OP_NOP = 4'hF;

    if (ALU_OP_W < 4 || OPCODE_W < 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("multicycle_control_unit: unsupported parameter set");
    end

    state_t                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [3:0]            op_q, op_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [CNT_W-1:0]      retired_q, retired_d;
    logic                  ack_ok;
    logic                  timeout;
    logic                  opc_illegal;
    logic [3:0]            opc4;
    logic                  retire;
    logic                  br_taken;

    assign ack_ok      = mem_req_q & mem_ack;
    assign opc_illegal = |(instr_opcode >> 4);
    assign opc4        = instr_opcode[3:0];

`ifdef MCU_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Down-counter reloads whenever no request is waiting; an ack in the terminal cycle wins.
    always_comb begin
        timeout = mem_req_q & ~mem_ack & (wait_q == '0);
        if (mem_req_q && !mem_ack && wait_q != '0) begin
            wait_d = wait_q - WAIT_W'(1);
        end else begin
            wait_d = WAIT_W'(TIMEOUT_CYCLES - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= WAIT_W'(TIMEOUT_CYCLES - 1);
        end else begin
            wait_q <= wait_d;
        end
    end

    assign mem_err = timeout;
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        alu_op_d   = alu_op_q;
        retired_d  = retired_q;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        imm_load   = 1'b0;
        illegal_op = 1'b0;
        retire     = 1'b0;
        br_taken   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (timeout) begin
                    state_d = S_FETCH;
                end else if (ack_ok) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!stall) begin
                    if (opc_illegal) begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        op_d     = opc4;
                        alu_op_d = ALU_OP_W'(opc4);
                        case (opc4)
                            OP_LDR, OP_STR:         state_d = S_MEM;
                            OP_JMP, OP_BEQ, OP_BNE: state_d = S_BRANCH;
                            OP_NOP: begin
                                retire  = 1'b1;
                                state_d = S_FETCH;
                            end
                            default:                state_d = S_EXEC;
                        endcase
                    end
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (timeout) begin
                    state_d = S_FETCH;
                end else if (ack_ok) begin
                    if (op_q == OP_STR) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                mem_to_reg = (op_q == OP_LDR);
                imm_load   = (op_q == OP_IMM);
                if (!stall) begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_BRANCH: begin
                br_taken = (op_q == OP_JMP) |
                           ((op_q == OP_BEQ) & zero_flag) |
                           ((op_q == OP_BNE) & ~zero_flag);
                if (!stall) begin
                    pc_load = br_taken;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // A timed-out request drops for one cycle before the refetch is issued.
        mem_req_d = ((state_d == S_FETCH) || (state_d == S_MEM)) && !timeout;
        if (state_d == S_FETCH) begin
            alu_op_d = '0;
        end
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            mem_req_q <= 1'b0;
            op_q      <= '0;
            alu_op_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            op_q      <= op_d;
            alu_op_q  <= alu_op_d;
            retired_q <= retired_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_is_fetch = mem_req_q & (state_q == S_FETCH);
    assign mem_we       = mem_req_q & (state_q == S_MEM) & (op_q == OP_STR);
    assign alu_op       = alu_op_q;
    assign retired      = retired_q;
    assign state        = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH states. It drives a ready/ack memory handshake, per-state datapath enables and a stall input, and counts retired instructions. It sits between the instruction register, register file, ALU, PC and the shared memory port.

Parameters:
OPCODE_W, 4, opcode width; codes 0x0-0xF are defined, codes >= 16 are illegal.
ALU_OP_W, 4, alu_op width, must be >= 4.
CNT_W, 16, width of the retired-instruction counter.
TIMEOUT_CYCLES, 255, memory-wait limit; used only when MCU_MEM_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
instr_opcode  in  OPCODE_W  opcode from the instruction register; valid in DECODE.
zero_flag  in  1  ALU zero flag; valid in BRANCH.
mem_ack  in  1  memory completes the current request; sampled only while mem_req=1.
stall  in  1  hold request; honoured only in DECODE, EXEC, WB and BRANCH.
mem_req  out  1  memory request, held until ack.
mem_we  out  1  write qualifier for a store.
mem_is_fetch  out  1  marks the request as an instruction fetch.
ir_load  out  1  one-cycle pulse: load the instruction register.
pc_inc  out  1  one-cycle pulse: PC <= PC+1.
pc_load  out  1  one-cycle pulse: PC <= branch target.
reg_write  out  1  one-cycle register-file write enable.
mem_to_reg  out  1  write-back source is memory (LDR).
imm_load  out  1  write-back source is the immediate (IMM).
alu_op  out  ALU_OP_W  ALU operation, zero-extended opcode.
illegal_op  out  1  one-cycle pulse on an undefined opcode.
mem_err  out  1  one-cycle pulse on a memory timeout (0 without the macro).
retired  out  CNT_W  count of completed instructions; wraps to 0.
state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5.

Behaviour:
- Reset (asynchronous, immediate):
  - state=FETCH; every output 0, including retired.
  - An in-flight mem_req drops immediately.
  - Registered outputs are 0 during reset. mem_req, mem_is_fetch, mem_we and alu_op are registered or gated so they are also 0 during reset.
  - The first mem_req rises in the first FETCH cycle after rst_n rises.
- FETCH:
  - mem_req=1, mem_is_fetch=1.
  - On mem_ack: ir_load=1 and pc_inc=1 for that single cycle, then go to DECODE.
- DECODE:
  - Latch instr_opcode into an internal op_q. alu_op <= op_q, held until the next FETCH.
  - 0x0-0x7, 0xA (MOV), 0xB (IMM) -> EXEC.
  - 0x8 (LDR), 0x9 (STR) -> MEM.
  - 0xC (JMP), 0xD (BEQ), 0xE (BNE) -> BRANCH.
  - 0xF (NOP) -> FETCH; retired increments.
  - Opcode >= 16: illegal_op pulse, -> FETCH; retired does not increment.
- EXEC: one cycle -> WB.
- MEM:
  - mem_req=1; mem_we=1 only for STR.
  - On mem_ack: LDR -> WB with mem_to_reg=1; STR -> FETCH and retired increments.
- WB:
  - reg_write=1 for one cycle; imm_load=1 for IMM.
  - Then -> FETCH; retired increments.
- BRANCH:
  - pc_load=1 when JMP, or BEQ with zero_flag=1, or BNE with zero_flag=0.
  - Then -> FETCH; retired increments.
- Latency with zero-wait ack (ack in the first request cycle):
  - ALU/MOV/IMM: 4 cycles.
  - LDR: 4 cycles.
  - STR, JMP, BEQ, BNE: 3 cycles.
  - NOP: 2 cycles.
  - Each memory wait cycle adds 1.
- stall=1 in DECODE/EXEC/WB/BRANCH:
  - The state holds.
  - reg_write, pc_load and illegal_op are suppressed until the cycle stall is low.
  - Each pulse fires exactly once.
- Memory states: stall is ignored in FETCH and MEM; mem_ack arriving while mem_req=0 is ignored.
- Mutual exclusion: mem_we=1 implies mem_req=1. pc_load and pc_inc are never both 1.
- Counter: retired wraps from 2^CNT_W-1 to 0 with no flag.

Optional Feature:
MCU_MEM_TIMEOUT_EN
- Defined:
  - A wait counter clears on entering FETCH or MEM and counts each cycle mem_req=1 without mem_ack.
  - On reaching TIMEOUT_CYCLES: mem_err pulses, mem_req drops and the FSM goes to FETCH.
  - pc_inc is not pulsed, so the same PC is retried. retired does not increment.
  - An ack arriving in the timeout cycle wins, and no error is flagged.
- Undefined: the FSM waits indefinitely, mem_err is tied to 0 and no counter logic exists.

Test Plan:
1. Reset release, opcode 0x0, ack in the first FETCH cycle -> states 0,1,2,4,0. reg_write high only in cycle 4. alu_op=0x0. retired=1.
2. LDR (0x8), fetch ack after 2 wait cycles, data ack after 3 -> mem_to_reg=1 in WB. One reg_write. Total 9 cycles. mem_we=0 throughout.
3. BEQ with zero_flag=0, then BEQ with zero_flag=1, then BNE with zero_flag=0 -> pc_load 0, 1, 1 respectively. pc_inc pulses once per fetch.
4. OPCODE_W=5, opcode 0x13 -> illegal_op pulses once, back to FETCH, retired unchanged. stall=1 for 3 cycles in WB -> a single reg_write pulse after stall falls.
5. CNT_W=4, run 17 NOPs -> retired=1. rst_n low mid-MEM of a STR -> mem_req falls asynchronously and state=0.
6. With MCU_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ack held low in FETCH -> mem_err pulses after 8 cycles, no pc_inc, refetch follows. Without the macro -> mem_req held indefinitely, mem_err=0.
